// File: rtl/x86_encoder.sv
// x86_encoder: serializes one 32-bit ADD/MOV request into x86 machine-code bytes, one byte per accepted beat
// Ports: i_clk/i_reset (sync, active-high); i_valid/o_ready request handshake carrying
// i_op, i_mod, i_reg, i_rm, i_scale, i_index, i_base, i_disp, i_op16;
// o_byte_valid/o_byte/i_byte_ready byte stream with o_last on the final byte and o_len total length.
// X86_ENC_OPSIZE_PREFIX_EN: when defined, i_op16=1 emits a 66h operand-size prefix.
module x86_encoder (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [1:0]  i_op,
  input  logic [1:0]  i_mod,
  input  logic [2:0]  i_reg,
  input  logic [2:0]  i_rm,
  input  logic [1:0]  i_scale,
  input  logic [2:0]  i_index,
  input  logic [2:0]  i_base,
  input  logic [31:0] i_disp,
  input  logic        i_op16,
  output logic        o_byte_valid,
  output logic [7:0]  o_byte,
  input  logic        i_byte_ready,
  output logic        o_last,
  output logic [3:0]  o_len
);
  typedef enum logic [2:0] {IDLE, PREFIX, OPCODE, MODRM, SIB, DISP} state_t;
  state_t state, nxt;
  logic [1:0] r_op, r_mod, r_scale, f_op, f_mod, f_scale;
  logic [2:0] r_reg, r_rm, r_index, r_base, f_reg, f_rm, f_index, f_base;
  logic [31:0] r_disp, f_disp;
  logic idle, pfx, sib, adv, last_nxt;
  logic [2:0] dlen;
  logic [1:0] cnt, cnt_nxt, last_cnt;
  logic [3:0] len;
  logic [7:0] byte_nxt;
  assign idle = state == IDLE;
  // In IDLE the first byte is built straight from the request so it can be registered on the accept edge
  assign f_op    = idle ? i_op    : r_op;
  assign f_mod   = idle ? i_mod   : r_mod;
  assign f_reg   = idle ? i_reg   : r_reg;
  assign f_rm    = idle ? i_rm    : r_rm;
  assign f_scale = idle ? i_scale : r_scale;
  assign f_index = idle ? i_index : r_index;
  assign f_base  = idle ? i_base  : r_base;
  assign f_disp  = idle ? i_disp  : r_disp;
`ifdef X86_ENC_OPSIZE_PREFIX_EN
  logic r_op16;
  assign pfx = idle ? i_op16 : r_op16;
  always_ff @(posedge i_clk)
    if (idle) r_op16 <= i_op16;
`else
  logic unused_op16;
  assign unused_op16 = i_op16;
  assign pfx = 1'b0;
`endif
  assign sib = f_mod != 2'b11 && f_rm == 3'b100;
  assign dlen = f_mod == 2'b01 ? 3'd1 :
                f_mod == 2'b10 ? 3'd4 :
                (f_mod == 2'b00 && (f_rm == 3'b101 || (sib && f_base == 3'b101))) ? 3'd4 : 3'd0;
  // dlen of 4 wraps to 3 in two bits, dlen of 1 gives 0
  assign last_cnt = dlen[1:0] - 2'd1;
  assign len = {3'b000, pfx} + 4'd2 + {3'b000, sib} + {1'b0, dlen};
  assign adv = idle ? i_valid : i_byte_ready;
  assign o_ready = idle & ~i_reset;
  assign cnt_nxt = state == DISP ? cnt + 2'd1 : 2'd0;
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = pfx ? PREFIX : OPCODE;
      PREFIX:  nxt = OPCODE;
      OPCODE:  nxt = MODRM;
      MODRM:   nxt = sib ? SIB : dlen != 3'd0 ? DISP : IDLE;
      SIB:     nxt = dlen != 3'd0 ? DISP : IDLE;
      DISP:    nxt = cnt == last_cnt ? IDLE : DISP;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    byte_nxt = 8'h00;
    case (nxt)
      PREFIX:  byte_nxt = 8'h66;
      OPCODE:  byte_nxt = {f_op[1], 3'b000, f_op[1], 1'b0, f_op[0], 1'b1};
      MODRM:   byte_nxt = {f_mod, f_reg, f_rm};
      SIB:     byte_nxt = {f_scale, f_index, f_base};
      DISP:    byte_nxt = f_disp[{cnt_nxt, 3'b000} +: 8];
      default: byte_nxt = 8'h00;
    endcase
  end
  assign last_nxt = nxt == DISP  ? cnt_nxt == last_cnt :
                    nxt == SIB   ? dlen == 3'd0 :
                    nxt == MODRM ? !sib && dlen == 3'd0 : 1'b0;
  always_ff @(posedge i_clk)
    if (idle) begin
      r_op <= i_op;
      r_mod <= i_mod;
      r_reg <= i_reg;
      r_rm <= i_rm;
      r_scale <= i_scale;
      r_index <= i_index;
      r_base <= i_base;
      r_disp <= i_disp;
    end
  always_ff @(posedge i_clk)
    if (i_reset) begin
      state <= IDLE;
      cnt <= 2'd0;
      o_byte_valid <= 1'b0;
      o_byte <= 8'h00;
      o_last <= 1'b0;
      o_len <= 4'd0;
    end else if (adv) begin
      state <= nxt;
      cnt <= cnt_nxt;
      o_byte_valid <= nxt != IDLE;
      o_byte <= byte_nxt;
      o_last <= last_nxt;
      o_len <= nxt == IDLE ? 4'd0 : len;
    end
endmodule

// File: tb/tb_x86_encoder.sv
// tb_x86_encoder: directed self-checking bench for x86_encoder
module tb_x86_encoder;
  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [1:0]  i_op = 2'b00;
  logic [1:0]  i_mod = 2'b00;
  logic [2:0]  i_reg = 3'b000;
  logic [2:0]  i_rm = 3'b000;
  logic [1:0]  i_scale = 2'b00;
  logic [2:0]  i_index = 3'b000;
  logic [2:0]  i_base = 3'b000;
  logic [31:0] i_disp = 32'h0;
  logic        i_op16 = 1'b0;
  logic        o_byte_valid;
  logic [7:0]  o_byte;
  logic        i_byte_ready = 1'b1;
  logic        o_last;
  logic [3:0]  o_len;
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] got_b [8];
  logic       got_last [8];
  int         got_n;
  logic [3:0] got_len;
  logic [7:0] exp_b [8];

  x86_encoder dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_mod(i_mod), .i_reg(i_reg), .i_rm(i_rm),
    .i_scale(i_scale), .i_index(i_index), .i_base(i_base), .i_disp(i_disp),
    .i_op16(i_op16), .o_byte_valid(o_byte_valid), .o_byte(o_byte),
    .i_byte_ready(i_byte_ready), .o_last(o_last), .o_len(o_len)
  );

  always #5 i_clk = ~i_clk;

  task automatic issue(input logic [1:0] op, input logic [1:0] md, input logic [2:0] rg,
                       input logic [2:0] rm, input logic [1:0] sc, input logic [2:0] ix,
                       input logic [2:0] bs, input logic [31:0] d, input logic p16);
    @(negedge i_clk);
    i_op = op; i_mod = md; i_reg = rg; i_rm = rm;
    i_scale = sc; i_index = ix; i_base = bs; i_disp = d; i_op16 = p16;
    i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  // Records presented bytes until o_last (ready held high); returns on the last byte's cycle
  task automatic collect();
    got_n = 0;
    got_len = 4'd0;
    for (int c = 0; c < 20; c++) begin
      if (o_byte_valid) begin
        if (got_n < 8) begin
          got_b[got_n] = o_byte;
          got_last[got_n] = o_last;
        end
        if (got_n == 0) got_len = o_len;
        got_n++;
        if (o_last) return;
      end
      @(negedge i_clk);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    n_cmp++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0", o_ready); end
    n_cmp++; if (o_byte_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", o_byte_valid); end
    n_cmp++; if (o_byte !== 8'h00) begin n_bad++; $display("FAIL reset_byte got %h want 00", o_byte); end
    n_cmp++; if (o_last !== 1'b0 || o_len !== 4'd0) begin n_bad++; $display("FAIL reset_last_len got %b/%0d want 0/0", o_last, o_len); end
    i_reset = 1'b0;
    @(negedge i_clk);
    n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset got %b want 1", o_ready); end
  endtask

  task automatic test_reg_reg(input string nm);
    issue(2'b00, 2'b11, 3'b000, 3'b001, 2'b00, 3'b000, 3'b000, 32'h0, 1'b0);
    n_cmp++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL %s ready_busy got %b want 0", nm, o_ready); end
    collect();
    n_cmp++; if (got_n !== 2 || got_len !== 4'd2) begin n_bad++; $display("FAIL %s count_len got %0d/%0d want 2/2", nm, got_n, got_len); end
    n_cmp++; if (got_b[0] !== 8'h01 || got_b[1] !== 8'hC1) begin n_bad++; $display("FAIL %s bytes got %h %h want 01 C1", nm, got_b[0], got_b[1]); end
    n_cmp++; if (got_last[0] !== 1'b0 || got_last[1] !== 1'b1) begin n_bad++; $display("FAIL %s last got %b%b want 01", nm, got_last[0], got_last[1]); end
    @(negedge i_clk);
    n_cmp++; if (o_ready !== 1'b1 || o_byte_valid !== 1'b0) begin n_bad++; $display("FAIL %s ready_after got %b/%b want 1/0", nm, o_ready, o_byte_valid); end
  endtask

  task automatic test_sib();
    exp_b[0] = 8'h8B; exp_b[1] = 8'h54; exp_b[2] = 8'h8B; exp_b[3] = 8'h10;
    issue(2'b11, 2'b01, 3'b010, 3'b100, 2'b10, 3'b001, 3'b011, 32'h00000010, 1'b0);
    collect();
    n_cmp++; if (got_n !== 4 || got_len !== 4'd4) begin n_bad++; $display("FAIL sib count_len got %0d/%0d want 4/4", got_n, got_len); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (got_b[i] !== exp_b[i]) begin n_bad++; $display("FAIL sib byte%0d got %h want %h", i, got_b[i], exp_b[i]); end
    end
  endtask

  task automatic test_disp32();
    exp_b[0] = 8'h89; exp_b[1] = 8'h1D; exp_b[2] = 8'h78; exp_b[3] = 8'h56; exp_b[4] = 8'h34; exp_b[5] = 8'h12;
    issue(2'b10, 2'b00, 3'b011, 3'b101, 2'b00, 3'b000, 3'b000, 32'h12345678, 1'b0);
    collect();
    n_cmp++; if (got_n !== 6 || got_len !== 4'd6) begin n_bad++; $display("FAIL disp32 count_len got %0d/%0d want 6/6", got_n, got_len); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (got_b[i] !== exp_b[i] || got_last[i] !== (i == 5)) begin n_bad++; $display("FAIL disp32 byte%0d got %h/%b want %h/%b", i, got_b[i], got_last[i], exp_b[i], i == 5); end
    end
  endtask

  task automatic test_backpressure();
    issue(2'b10, 2'b00, 3'b011, 3'b101, 2'b00, 3'b000, 3'b000, 32'h12345678, 1'b0);
    for (int i = 0; i < 3; i++) @(negedge i_clk);
    n_cmp++; if (o_byte !== 8'h56 || o_byte_valid !== 1'b1) begin n_bad++; $display("FAIL bp_present got %h/%b want 56/1", o_byte, o_byte_valid); end
    i_byte_ready = 1'b0;
    i_valid = 1'b1; i_op = 2'b01; i_mod = 2'b11; i_rm = 3'b000; i_disp = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      n_cmp++; if (o_byte !== 8'h56 || o_byte_valid !== 1'b1 || o_last !== 1'b0 || o_len !== 4'd6) begin
        n_bad++; $display("FAIL bp_hold%0d got %h/%b/%b/%0d want 56/1/0/6", i, o_byte, o_byte_valid, o_last, o_len);
      end
    end
    i_byte_ready = 1'b1;
    i_valid = 1'b0;
    @(negedge i_clk);
    n_cmp++; if (o_byte !== 8'h34 || o_last !== 1'b0) begin n_bad++; $display("FAIL bp_next got %h/%b want 34/0", o_byte, o_last); end
    @(negedge i_clk);
    n_cmp++; if (o_byte !== 8'h12 || o_last !== 1'b1) begin n_bad++; $display("FAIL bp_final got %h/%b want 12/1", o_byte, o_last); end
  endtask

  task automatic test_reset_mid();
    issue(2'b10, 2'b00, 3'b011, 3'b101, 2'b00, 3'b000, 3'b000, 32'h12345678, 1'b0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    n_cmp++; if (o_byte_valid !== 1'b0 || o_last !== 1'b0 || o_byte !== 8'h00 || o_len !== 4'd0 || o_ready !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset got v%b l%b b%h n%0d r%b want 0/0/00/0/0", o_byte_valid, o_last, o_byte, o_len, o_ready);
    end
    i_reset = 1'b0;
    test_reg_reg("after_reset");
  endtask

  task automatic test_back_to_back();
    issue(2'b00, 2'b11, 3'b000, 3'b001, 2'b00, 3'b000, 3'b000, 32'h0, 1'b0);
    @(negedge i_clk);
    // second request presented while the first is still streaming; taken only once idle
    i_op = 2'b01; i_mod = 2'b11; i_reg = 3'b010; i_rm = 3'b011; i_valid = 1'b1;
    n_cmp++; if (o_byte !== 8'hC1 || o_last !== 1'b1) begin n_bad++; $display("FAIL b2b_first got %h/%b want C1/1", o_byte, o_last); end
    @(negedge i_clk);
    n_cmp++; if (o_ready !== 1'b1 || o_byte_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_gap got %b/%b want 1/0", o_ready, o_byte_valid); end
    @(negedge i_clk);
    i_valid = 1'b0;
    collect();
    n_cmp++; if (got_n !== 2 || got_b[0] !== 8'h03 || got_b[1] !== 8'hD3) begin n_bad++; $display("FAIL b2b_second got %0d %h %h want 2 03 D3", got_n, got_b[0], got_b[1]); end
  endtask

  task automatic test_prefix();
    issue(2'b00, 2'b11, 3'b000, 3'b001, 2'b00, 3'b000, 3'b000, 32'h0, 1'b1);
    collect();
`ifdef X86_ENC_OPSIZE_PREFIX_EN
    n_cmp++; if (got_n !== 3 || got_len !== 4'd3 || got_b[0] !== 8'h66 || got_b[1] !== 8'h01 || got_b[2] !== 8'hC1) begin
      n_bad++; $display("FAIL prefix got n%0d len%0d %h %h %h want 3/3 66 01 C1", got_n, got_len, got_b[0], got_b[1], got_b[2]);
    end
`else
    n_cmp++; if (got_n !== 2 || got_len !== 4'd2 || got_b[0] !== 8'h01 || got_b[1] !== 8'hC1) begin
      n_bad++; $display("FAIL prefix_off got n%0d len%0d %h %h want 2/2 01 C1", got_n, got_len, got_b[0], got_b[1]);
    end
`endif
    i_op16 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reg_reg("reg_reg");
    test_sib();
    test_disp32();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_prefix();
    @(negedge i_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
